// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: merges ALU and mult/div writebacks through an in-order FIFO.
// Optional store-to-read forwarding of pending data is enabled by defining REGFILE_WB_FWD_EN.
module regfile_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_reg,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    md_valid,
    output logic                    md_ready,
    input  logic [ADDR_W-1:0]       md_reg,
    input  logic [DATA_W-1:0]       md_data,
    input  logic                    wb_stall,
    output logic                    ctrl_writeEnable,
    output logic [ADDR_W-1:0]       ctrl_writeReg,
    output logic [DATA_W-1:0]       data_writeReg,
    input  logic [ADDR_W-1:0]       query_regA,
    input  logic [ADDR_W-1:0]       query_regB,
    output logic                    pendingA,
    output logic                    pendingB,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [DATA_W-1:0]       fwd_dataA,
    output logic [DATA_W-1:0]       fwd_dataB
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
    logic [ADDR_W-1:0] reg_mem_d  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_s, space_s, md_fire_s, alu_fire_s, push_s, not_empty_s;
    logic [ADDR_W-1:0] push_reg_s;
    logic [DATA_W-1:0] push_data_s;
    logic [PTR_W-1:0]  slot_s  [DEPTH];
    logic [DEPTH-1:0]  hit_a_s, hit_b_s;

    // Handshake, drain decision and write-port drive
    always_comb begin
        not_empty_s      = (count_q != {CNT_W{1'b0}});
        pop_s            = not_empty_s & ~wb_stall & ~ctrl_reset;
        space_s          = ((count_q < DEPTH_C) | pop_s) & ~ctrl_reset;
        md_ready         = space_s;
        alu_ready        = space_s & ~md_valid;
        md_fire_s        = md_valid & md_ready;
        alu_fire_s       = alu_valid & alu_ready;
        push_reg_s       = md_fire_s ? md_reg  : alu_reg;
        push_data_s      = md_fire_s ? md_data : alu_data;
        // Writes to the hardwired zero register are acknowledged and dropped
        push_s           = (md_fire_s | alu_fire_s) & (push_reg_s != {ADDR_W{1'b0}});
        ctrl_writeEnable = pop_s;
        ctrl_writeReg    = not_empty_s ? reg_mem_q[head_q]  : {ADDR_W{1'b0}};
        data_writeReg    = not_empty_s ? data_mem_q[head_q] : {DATA_W{1'b0}};
        fifo_count       = count_q;
    end

    // FIFO next-state: enqueue at tail, dequeue at head, occupancy update
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        if (ctrl_reset) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                reg_mem_d[tail_q]  = push_reg_s;
                data_mem_d[tail_q] = push_data_s;
                tail_d             = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            head_d = pop_s ? (head_q + PTR_ONE) : head_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        head_q     <= head_d;
        tail_q     <= tail_d;
        count_q    <= count_d;
        reg_mem_q  <= reg_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Hazard match per entry, walked oldest (k=0) to youngest
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_s[k]  = head_q + PTR_W'(k);
            hit_a_s[k] = (CNT_W'(k) < count_q) & (reg_mem_q[slot_s[k]] == query_regA) &
                         (query_regA != {ADDR_W{1'b0}}) & ~ctrl_reset;
            hit_b_s[k] = (CNT_W'(k) < count_q) & (reg_mem_q[slot_s[k]] == query_regB) &
                         (query_regB != {ADDR_W{1'b0}}) & ~ctrl_reset;
        end
        pendingA = |hit_a_s;
        pendingB = |hit_b_s;
    end

`ifdef REGFILE_WB_FWD_EN
    // Forward the youngest matching entry; later hits overwrite earlier ones
    always_comb begin
        fwd_dataA = {DATA_W{1'b0}};
        fwd_dataB = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            fwd_dataA = hit_a_s[k] ? data_mem_q[slot_s[k]] : fwd_dataA;
            fwd_dataB = hit_b_s[k] ? data_mem_q[slot_s[k]] : fwd_dataB;
        end
    end
`else
    assign fwd_dataA = {DATA_W{1'b0}};
    assign fwd_dataB = {DATA_W{1'b0}};
`endif

endmodule
